// File: rtl/sound_arbiter_pkg.sv
// Shared definitions for the logo-animation sound path.
// Contents:
//   SND_* tone codes  - also used by the tone generator
//   state_t           - arbiter FSM states IDLE / PLAY / GAP
//   code_onehot()     - tone code to one-hot grant vector
//   pick_winner()     - fixed-priority / round-robin selection over candidate requests
package sound_arbiter_pkg;

  localparam logic [1:0] SND_PING = 2'b00;
  localparam logic [1:0] SND_PONG = 2'b01;
  localparam logic [1:0] SND_GO   = 2'b10;
  localparam logic [1:0] SND_STOP = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_PLAY = 2'b01,
    ST_GAP  = 2'b10
  } state_t;

  function automatic logic [3:0] code_onehot(input logic [1:0] code);
    logic [3:0] oh;
    oh       = 4'b0000;
    oh[code] = 1'b1;
    return oh;
  endfunction

  // stop beats go beats ping/pong; ping/pong ties are broken by rr
  // (rr = 0 prefers ping, rr = 1 prefers pong).
  function automatic logic [1:0] pick_winner(input logic [3:0] cand, input logic rr);
    logic [1:0] win;
    if (cand[3]) begin
      win = SND_STOP;
    end else if (cand[2]) begin
      win = SND_GO;
    end else if (cand[0] && cand[1]) begin
      win = rr ? SND_PONG : SND_PING;
    end else if (cand[1]) begin
      win = SND_PONG;
    end else begin
      win = SND_PING;
    end
    return win;
  endfunction

endpackage

// File: rtl/sound_timer.sv
// Loadable down-counter that times tone and gap durations.
// Ports:
//   clk   in  1      system clock
//   clr   in  1      asynchronous active-high reset (count -> 0)
//   load  in  1      load value on this edge (takes priority over counting)
//   value in  CNT_W  reload value
//   zero  out 1      count is zero
// The counter saturates at zero; the arbiter always reloads before it would wrap.
module sound_timer
  import sound_arbiter_pkg::*;
#(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  output logic             zero
);

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_r;

  // Count register: load, otherwise decrement toward zero and stop there.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      count_r <= CNT_ZERO;
    end else if (load) begin
      count_r <= value;
    end else if (count_r != CNT_ZERO) begin
      count_r <= count_r - CNT_ONE;
    end else begin
      count_r <= count_r;
    end
  end

  assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/sound_arbiter.sv
// Shares one tone generator among ping / pong / go / stop sound events.
// Event pulses are latched as pending, one winner is granted per playback slot,
// the tone plays for TONE_CYCLES clocks and is followed by GAP_CYCLES of silence.
// Ports:
//   clk, clr                     clock, asynchronous active-high reset
//   req_ping/pong/go/stop  in    one-cycle event pulses
//   enable                 in    1 = new grants allowed (requests always latched)
//   mute                   out   1 = silence
//   code_sound             out 2 tone code, held while muted
//   grant                  out 4 one-hot pulse on slot start, bit index = code
//   busy                   out   1 while in PLAY or GAP
module sound_arbiter
  import sound_arbiter_pkg::*;
#(
  parameter int TONE_CYCLES = 2_500_000,
  parameter int GAP_CYCLES  = 250_000,
  parameter int CNT_W       = 24
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req_ping,
  input  logic       req_pong,
  input  logic       req_go,
  input  logic       req_stop,
  input  logic       enable,
  output logic       mute,
  output logic [1:0] code_sound,
  output logic [3:0] grant,
  output logic       busy
);

  localparam logic [CNT_W-1:0] TONE_LOAD = CNT_W'(TONE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  state_t           state_r, state_nxt_s;
  logic [3:0]       pending_r, pending_nxt_s;
  logic             rr_r, rr_nxt_s;
  logic             mute_r, mute_nxt_s;
  logic [1:0]       code_r, code_nxt_s;
  logic [3:0]       grant_r, grant_nxt_s;
  logic             busy_r, busy_nxt_s;

  logic [3:0]       req_s;
  logic [3:0]       cand_s;
  logic [1:0]       winner_s;
  logic             start_s;
  logic             preempt_s;
  logic             to_gap_s;
  logic             timer_load_s;
  logic [CNT_W-1:0] timer_value_s;
  logic             timer_zero_s;

  assign req_s    = {req_stop, req_go, req_pong, req_ping};
  // A request arriving this cycle competes alongside already-pending ones.
  assign cand_s   = pending_r | req_s;
  assign winner_s = pick_winner(cand_s, rr_r);

  sound_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk   (clk),
    .clr   (clr),
    .load  (timer_load_s),
    .value (timer_value_s),
    .zero  (timer_zero_s)
  );

  // State, pending, round-robin and output registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r   <= ST_IDLE;
      pending_r <= 4'b0000;
      rr_r      <= 1'b0;
      mute_r    <= 1'b1;
      code_r    <= SND_PING;
      grant_r   <= 4'b0000;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
      rr_r      <= rr_nxt_s;
      mute_r    <= mute_nxt_s;
      code_r    <= code_nxt_s;
      grant_r   <= grant_nxt_s;
      busy_r    <= busy_nxt_s;
    end
  end

  // Next-state logic; also flags slot start, stop preemption and tone end.
  always_comb begin
    state_nxt_s = state_r;
    start_s     = 1'b0;
    preempt_s   = 1'b0;
    to_gap_s    = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (enable && (cand_s != 4'b0000)) begin
          start_s     = 1'b1;
          state_nxt_s = ST_PLAY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_PLAY: begin
        // stop cuts short any other tone but never restarts itself.
        if (enable && cand_s[3] && (code_r != SND_STOP)) begin
          start_s     = 1'b1;
          preempt_s   = 1'b1;
          state_nxt_s = ST_PLAY;
        end else if (timer_zero_s) begin
          to_gap_s    = 1'b1;
          state_nxt_s = ST_GAP;
        end else begin
          state_nxt_s = ST_PLAY;
        end
      end
      ST_GAP: begin
        if (timer_zero_s) begin
          if (enable && (cand_s != 4'b0000)) begin
            start_s     = 1'b1;
            state_nxt_s = ST_PLAY;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end else begin
          state_nxt_s = ST_GAP;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Output next values and timer reload control.
  always_comb begin
    mute_nxt_s    = mute_r;
    code_nxt_s    = code_r;
    grant_nxt_s   = 4'b0000;
    busy_nxt_s    = busy_r;
    timer_load_s  = 1'b0;
    timer_value_s = TONE_LOAD;
    if (start_s) begin
      mute_nxt_s    = 1'b0;
      code_nxt_s    = winner_s;
      grant_nxt_s   = code_onehot(winner_s);
      busy_nxt_s    = 1'b1;
      timer_load_s  = 1'b1;
      timer_value_s = TONE_LOAD;
    end else if (to_gap_s) begin
      mute_nxt_s    = 1'b1;
      timer_load_s  = 1'b1;
      timer_value_s = GAP_LOAD;
    end else if ((state_r == ST_GAP) && timer_zero_s) begin
      busy_nxt_s    = 1'b0;
    end else begin
      busy_nxt_s    = busy_r;
    end
  end

  // Pending latch and ping/pong round-robin pointer.
  always_comb begin
    pending_nxt_s = cand_s;
    rr_nxt_s      = rr_r;
    if (start_s) begin
      // A fresh pulse of an already-pending code on its grant edge is kept,
      // so it replays in a later slot.
      if (!(pending_r[winner_s] && req_s[winner_s])) begin
        pending_nxt_s[winner_s] = 1'b0;
      end else begin
        pending_nxt_s[winner_s] = 1'b1;
      end
      if (preempt_s) begin
        pending_nxt_s[1:0] = 2'b00;
      end else begin
        pending_nxt_s[1:0] = pending_nxt_s[1:0];
      end
      if (winner_s == SND_PING) begin
        rr_nxt_s = 1'b1;
      end else if (winner_s == SND_PONG) begin
        rr_nxt_s = 1'b0;
      end else begin
        rr_nxt_s = rr_r;
      end
    end else begin
      rr_nxt_s = rr_r;
    end
  end

  assign mute       = mute_r;
  assign code_sound = code_r;
  assign grant      = grant_r;
  assign busy       = busy_r;

endmodule

// File: tb/tb_sound_arbiter.sv
// Bench for sound_arbiter with TONE_CYCLES=8, GAP_CYCLES=3.
// A slot-level model tracks phase (idle/tone/gap) and cycles left in the phase;
// outputs are compared against it on every falling edge, and directed
// scenarios pin the expected timing with literal values.
module tb_sound_arbiter;

  localparam int TONE = 8;
  localparam int GAP  = 3;

  logic       clk = 1'b0;
  logic       clr;
  logic       req_ping = 1'b0, req_pong = 1'b0, req_go = 1'b0, req_stop = 1'b0;
  logic       enable = 1'b1;
  logic       mute;
  logic [1:0] code_sound;
  logic [3:0] grant;
  logic       busy;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  sound_arbiter #(
    .TONE_CYCLES (TONE),
    .GAP_CYCLES  (GAP),
    .CNT_W       (24)
  ) dut (
    .clk        (clk),
    .clr        (clr),
    .req_ping   (req_ping),
    .req_pong   (req_pong),
    .req_go     (req_go),
    .req_stop   (req_stop),
    .enable     (enable),
    .mute       (mute),
    .code_sound (code_sound),
    .grant      (grant),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // phase: 0 idle, 1 tone, 2 gap; left = cycles of the current phase still to show
  typedef struct packed {
    logic [1:0] phase;
    int         left;
    logic [1:0] code;
    logic [3:0] grant;
    logic [3:0] pend;
    logic       rr_pong;
  } model_t;

  localparam model_t M_RESET = '{phase: 2'd0, left: 0, code: 2'd0, grant: 4'd0, pend: 4'd0, rr_pong: 1'b0};

  model_t m;

  function automatic int choose(input logic [3:0] cand, input logic rr_pong);
    if (cand[3]) return 3;
    if (cand[2]) return 2;
    if (cand[0] && cand[1]) return rr_pong ? 1 : 0;
    if (cand[1]) return 1;
    return 0;
  endfunction

  function automatic model_t step(input model_t cur, input logic [3:0] req, input logic en);
    model_t     n;
    logic [3:0] cand;
    bit         start;
    bit         preempt;
    int         win;
    n       = cur;
    cand    = cur.pend | req;
    n.grant = 4'd0;
    start   = 1'b0;
    preempt = 1'b0;
    if (cur.phase == 2'd0) begin
      start = en && (cand != 4'd0);
    end else if (cur.phase == 2'd1) begin
      if (en && cand[3] && cur.code != 2'd3) begin
        start   = 1'b1;
        preempt = 1'b1;
      end else if (cur.left == 1) begin
        n.phase = 2'd2;
        n.left  = GAP;
      end else begin
        n.left = cur.left - 1;
      end
    end else begin
      if (cur.left == 1) begin
        if (en && cand != 4'd0) start = 1'b1;
        else n.phase = 2'd0;
      end else begin
        n.left = cur.left - 1;
      end
    end
    n.pend = cand;
    if (start) begin
      win = choose(cand, cur.rr_pong);
      if (!(cur.pend[win] && req[win])) n.pend[win] = 1'b0;
      if (preempt) n.pend[1:0] = 2'b00;
      if (win < 2) n.rr_pong = (win == 0);
      n.code  = 2'(win);
      n.phase = 2'd1;
      n.left  = TONE;
      n.grant = 4'(1 << win);
    end
    return n;
  endfunction

  always @(posedge clk or posedge clr) begin
    if (clr) m <= M_RESET;
    else     m <= step(m, {req_stop, req_go, req_pong, req_ping}, enable);
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("model_mute",  32'(mute),       32'(m.phase != 2'd1));
      check("model_busy",  32'(busy),       32'(m.phase != 2'd0));
      check("model_code",  32'(code_sound), 32'(m.code));
      check("model_grant", 32'(grant),      32'(m.grant));
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Drive a one-cycle request pattern {stop,go,pong,ping}; returns on the
  // falling edge after the sampling edge, where the response is visible.
  task automatic pulse(input logic [3:0] r);
    {req_stop, req_go, req_pong, req_ping} = r;
    @(negedge clk);
    {req_stop, req_go, req_pong, req_ping} = 4'b0000;
  endtask

  initial begin
    clr = 1'b1;
    wait_n(3);
    clr = 1'b0;
    chk_en = 1'b1;

    // reset state
    check("rst_mute",  32'(mute),       32'd1);
    check("rst_code",  32'(code_sound), 32'd0);
    check("rst_grant", 32'(grant),      32'd0);
    check("rst_busy",  32'(busy),       32'd0);
    wait_n(4);

    // single pong: 8 tone cycles, 3 gap, then idle
    pulse(4'b0010);
    check("t2_grant", 32'(grant),      32'h2);
    check("t2_code",  32'(code_sound), 32'd1);
    check("t2_mute",  32'(mute),       32'd0);
    wait_n(7);
    check("t2_tone_last", 32'(mute), 32'd0);
    wait_n(1);
    check("t2_gap_mute",  32'(mute),  32'd1);
    check("t2_gap_busy",  32'(busy),  32'd1);
    check("t2_gap_grant", 32'(grant), 32'd0);
    wait_n(2);
    check("t2_gap_end_busy", 32'(busy), 32'd1);
    wait_n(1);
    check("t2_idle_busy", 32'(busy),       32'd0);
    check("t2_held_code", 32'(code_sound), 32'd1);
    wait_n(3);

    // ping+pong together: ping then pong back-to-back
    pulse(4'b0011);
    check("t3a_first", 32'(grant), 32'h1);
    wait_n(11);
    check("t3a_second",     32'(grant), 32'h2);
    check("t3a_second_mute", 32'(mute), 32'd0);
    wait_n(11);
    check("t3a_idle", 32'(busy), 32'd0);
    // lone ping moves rr to pong, so the next pair starts with pong
    pulse(4'b0001);
    check("t3_lone_ping", 32'(grant), 32'h1);
    wait_n(11);
    pulse(4'b0011);
    check("t3b_first", 32'(grant), 32'h2);
    wait_n(11);
    check("t3b_second", 32'(grant), 32'h1);
    wait_n(11);
    check("t3b_idle", 32'(busy), 32'd0);

    // go+ping+stop together: stop, go, ping
    pulse(4'b1101);
    check("t4_stop", 32'(grant), 32'h8);
    wait_n(11);
    check("t4_go", 32'(grant), 32'h4);
    wait_n(11);
    check("t4_ping", 32'(grant), 32'h1);
    wait_n(11);
    check("t4_idle", 32'(busy), 32'd0);
    wait_n(2);

    // stop preempts ping; pending pong dropped, pending go kept
    pulse(4'b0001);
    check("t5_ping", 32'(grant), 32'h1);
    pulse(4'b0100);
    check("t5_go_no_preempt", 32'(code_sound), 32'd0);
    check("t5_go_no_grant",   32'(grant),      32'd0);
    pulse(4'b0010);
    pulse(4'b1000);
    check("t5_stop_grant", 32'(grant),      32'h8);
    check("t5_stop_code",  32'(code_sound), 32'd3);
    check("t5_stop_mute",  32'(mute),       32'd0);
    wait_n(7);
    check("t5_stop_tone_last", 32'(mute), 32'd0);
    wait_n(1);
    check("t5_stop_gap", 32'(mute), 32'd1);
    wait_n(3);
    check("t5_go_after", 32'(grant),      32'h4);
    check("t5_go_code",  32'(code_sound), 32'd2);
    wait_n(11);
    check("t5_no_replay_busy",  32'(busy),  32'd0);
    check("t5_no_replay_grant", 32'(grant), 32'd0);
    wait_n(2);

    // enable low: go latched, merged, granted once when enabled
    enable = 1'b0;
    pulse(4'b0100);
    check("t6_no_grant", 32'(grant), 32'd0);
    check("t6_mute",     32'(mute),  32'd1);
    wait_n(5);
    pulse(4'b0100);
    wait_n(5);
    pulse(4'b0100);
    wait_n(7);
    check("t6_still_idle", 32'(busy), 32'd0);
    check("t6_still_mute", 32'(mute), 32'd1);
    enable = 1'b1;
    wait_n(1);
    check("t6_go_grant", 32'(grant), 32'h4);
    wait_n(11);
    check("t6_single_busy",  32'(busy),  32'd0);
    check("t6_single_grant", 32'(grant), 32'd0);
    wait_n(2);

    // clr mid-playback with a ping pending
    pulse(4'b0010);
    wait_n(2);
    pulse(4'b0001);
    wait_n(1);
    #2 clr = 1'b1;
    #1;
    check("t1_mute",  32'(mute),       32'd1);
    check("t1_code",  32'(code_sound), 32'd0);
    check("t1_grant", 32'(grant),      32'd0);
    check("t1_busy",  32'(busy),       32'd0);
    @(negedge clk);
    #2 clr = 1'b0;
    wait_n(15);
    check("t1_no_tone_busy", 32'(busy), 32'd0);
    check("t1_no_tone_mute", 32'(mute), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
